// File: rtl/icache_2way_if.sv
// icache_2way_if: fetch-side and refill-side signals of the 2-way instruction cache.
interface icache_2way_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc;
  logic            fetch_en;
  logic            flush;
  logic            mem_ready;
  logic [XLEN-1:0] mem_data;
  logic            hit;
  logic            miss;
  logic            ready;
  logic [XLEN-1:0] instruction;
  logic            mem_read;
  logic [XLEN-1:0] mem_addr;
  logic            busy;
  modport master (output pc, fetch_en, flush, mem_ready, mem_data,
                  input  hit, miss, ready, instruction, mem_read, mem_addr, busy);
  modport slave  (input  pc, fetch_en, flush, mem_ready, mem_data,
                  output hit, miss, ready, instruction, mem_read, mem_addr, busy);
endinterface

// File: rtl/icache_2way.sv
// icache_2way: blocking 2-way set-associative I-cache with LRU, word-serial refill and sequential flush.
module icache_2way #(
  parameter int XLEN       = 32,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input logic          clk,
  input logic          reset,
  icache_2way_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - OFF_W - 2;
  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;
  state_t            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [OFF_W-1:0]  wcnt_q, wcnt_d;
  logic [IDX_W-1:0]  fcnt_q, fcnt_d, ridx_q, ridx_d;
  logic [TAG_W-1:0]  rtag_q, rtag_d;
  logic              victim_q, victim_d, pend_q, pend_d;
  logic [1:0]        valid_q [SETS];
  logic [1:0]        valid_d [SETS];
  logic [SETS-1:0]   lru_q, lru_d;
  logic [TAG_W-1:0]  tag_q [2][SETS];
  logic [XLEN-1:0]   data_q [2][SETS][LINE_WORDS];
  logic              data_we, fill;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              m0, m1, idle;
  logic              unused_pc;
  assign off  = bus.pc[OFF_W+1:2];
  assign idx  = bus.pc[IDX_W+OFF_W+1:OFF_W+2];
  assign tag  = bus.pc[XLEN-1:IDX_W+OFF_W+2];
  assign unused_pc = ^bus.pc[1:0];
  assign m0   = valid_q[idx][0] && tag_q[0][idx] == tag;
  assign m1   = valid_q[idx][1] && tag_q[1][idx] == tag;
  assign idle = state_q == IDLE;
  assign bus.hit         = bus.fetch_en && idle && (m0 || m1);
  assign bus.miss        = bus.fetch_en && idle && !(m0 || m1);
  assign bus.ready       = bus.hit;
  assign bus.instruction = m0 ? data_q[0][idx][off] : m1 ? data_q[1][idx][off] : '0;
  assign bus.busy        = !idle;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_addr    = mem_addr_q;
  always_comb begin
    state_d    = state_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    wcnt_d     = wcnt_q;
    fcnt_d     = fcnt_q;
    ridx_d     = ridx_q;
    rtag_d     = rtag_q;
    victim_d   = victim_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    lru_d      = lru_q;
    data_we    = 1'b0;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.hit) lru_d[idx] = m0;
        if (bus.flush || pend_q) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end else if (bus.miss) begin
          ridx_d     = idx;
          rtag_d     = tag;
          victim_d   = !valid_q[idx][0] ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
          mem_addr_d = {bus.pc[XLEN-1:OFF_W+2], {(OFF_W+2){1'b0}}};
          mem_read_d = 1'b1;
          wcnt_d     = '0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        pend_d = pend_q || bus.flush;
        if (bus.mem_ready) begin
          data_we = 1'b1;
          if (wcnt_q != OFF_W'(LINE_WORDS - 1)) begin
            wcnt_d     = wcnt_q + 1'b1;
            mem_addr_d = mem_addr_q + XLEN'(4);
          end else begin
            fill                     = 1'b1;
            valid_d[ridx_q][victim_q] = 1'b1;
            lru_d[ridx_q]            = ~victim_q;
            mem_read_d               = 1'b0;
            // a flush seen during refill goes straight to FLUSH so no lookup slips in first
            state_d                  = (pend_q || bus.flush) ? FLUSH : IDLE;
            fcnt_d                   = '0;
          end
        end
      end
      FLUSH: begin
        valid_d[fcnt_q] = 2'b00;
        lru_d[fcnt_q]   = 1'b0;
        fcnt_d          = fcnt_q + 1'b1;
        if (fcnt_q == IDX_W'(SETS - 1)) begin
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      wcnt_q     <= '0;
      fcnt_q     <= '0;
      ridx_q     <= '0;
      rtag_q     <= '0;
      victim_q   <= 1'b0;
      pend_q     <= 1'b0;
      valid_q    <= '{default: '0};
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      wcnt_q     <= wcnt_d;
      fcnt_q     <= fcnt_d;
      ridx_q     <= ridx_d;
      rtag_q     <= rtag_d;
      victim_q   <= victim_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      lru_q      <= lru_d;
    end
  end
  // line storage carries no reset; valid bits guard it
  always_ff @(posedge clk) begin
    if (data_we) data_q[victim_q][ridx_q][wcnt_q] <= bus.mem_data;
    if (fill) tag_q[victim_q][ridx_q] <= rtag_q;
  end
endmodule

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Parametrised, 2-way set-associative, blocking instruction cache between the fetch stage and the instruction memory port.
- Adds configurable set count and line length, per-set LRU replacement, and a sequential flush for fence.i.
- Refills one word per mem_ready beat, in order from word 0.
- Fetch sees a combinational hit path: instruction and ready are valid in the same cycle as pc.

Parameters:
- XLEN, 32, address/data width.
- SETS, 32, number of sets; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- Derived widths: OFF_W = log2(LINE_WORDS); IDX_W = log2(SETS); TAG_W = XLEN - IDX_W - OFF_W - 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- pc  in  XLEN  fetch address; bits [1:0] ignored.
- fetch_en  in  1  fetch request this cycle.
- flush  in  1  single-cycle pulse; invalidate all lines.
- mem_ready  in  1  mem_data valid for the current mem_addr.
- mem_data  in  XLEN  refill word.
- hit  out  1  lookup hit (comb).
- miss  out  1  lookup miss (comb).
- ready  out  1  instruction valid this cycle (comb).
- instruction  out  XLEN  selected word (comb).
- mem_read  out  1  refill request (registered).
- mem_addr  out  XLEN  refill word address (registered).
- busy  out  1  state != IDLE (comb).

Behaviour:
- Address split:
  - offset = pc[OFF_W+1:2]
  - index = pc[IDX_W+OFF_W+1:OFF_W+2]
  - tag = pc[XLEN-1:IDX_W+OFF_W+2]
- Storage per set: valid[2], tag[2], data[2][LINE_WORDS], lru (1 bit, names the way to evict next).
- Lookup: way w matches when valid[w] && tag[w] == tag.
  - hit = fetch_en && state==IDLE && any match.
  - miss = fetch_en && state==IDLE && no match.
  - ready = hit.
  - instruction = data of the matching way at offset; 0 when no match.
  - Both ways matching cannot occur; if it does, way 0 has priority.
- LRU on a hit: lru[index] <= ~matching_way.
- Reset values:
  - state IDLE, mem_read 0, mem_addr 0, word counter 0, pending flush 0.
  - All valid and lru bits 0.
  - Data arrays are not reset.
  - A reset mid-refill or mid-flush aborts immediately; the partial line is never marked valid.
- State IDLE:
  - flush (or pending flush) takes priority over miss: go to FLUSH with set counter 0.
  - Otherwise, on miss:
    - Latch index, tag and victim. Victim is way 0 if invalid, else way 1 if invalid, else lru[index].
    - mem_addr <= {pc[XLEN-1:OFF_W+2], zeros}; mem_read <= 1; word counter <= 0; go to REFILL.
- State REFILL:
  - On each mem_ready: data[victim][counter] <= mem_data.
  - If counter != LINE_WORDS-1: counter +1, mem_addr +4.
  - On the last word:
    - valid[victim] <= 1; tag[victim] <= latched tag; lru <= ~victim.
    - mem_read <= 0; return to IDLE.
  - mem_read stays 1 and mem_addr holds while mem_ready is low (no timeout).
  - Refill uses the latched index/tag; pc and fetch_en changes are ignored until the refill ends.
  - The refilled fetch hits in the first IDLE cycle after the last beat (miss-to-ready = LINE_WORDS beats + 1 cycle).
  - A flush arriving during REFILL sets pending flush; it is serviced on return to IDLE, before any lookup (hit/miss are 0 while FLUSH is active).
- State FLUSH:
  - Each cycle: clear valid[0], valid[1] and lru for the current set; counter +1.
  - After set SETS-1: clear pending flush and return to IDLE.
  - Takes exactly SETS cycles. flush pulses during FLUSH are absorbed.
- mem_data is ignored outside REFILL. mem_read is never asserted in IDLE or FLUSH.

Test Plan (defaults: SETS=32, LINE_WORDS=4):
- Cold miss:
  - Stimulus: reset, then fetch_en with pc=0x0000_0104; memory returns 0xA0..0xA3 with mem_ready every cycle.
  - Required: miss=1 in cycle 0; mem_addr steps 0x100, 0x104, 0x108, 0x10C; mem_read drops after the 4th beat; next cycle hit=1, ready=1, instruction=0xA1.
- Stalled memory:
  - Stimulus: same miss with mem_ready low for 3 cycles between beats.
  - Required: mem_addr and mem_read held during stalls; line is correct after the 4 accepted beats.
- Two-way fill and LRU eviction:
  - Stimulus: fill 0x100 (way 0) and 0x300 (way 1), both set 16; then hit 0x100; then miss on 0x500.
  - Required: 0x500 replaces way 1 (0x300); 0x100 still hits; 0x300 misses.
- Flush:
  - Stimulus: fill 0x100, pulse flush, fetch 0x100.
  - Required: busy=1 for exactly 32 cycles with hit=miss=0; then miss=1 on 0x100.
- Flush during refill:
  - Stimulus: pulse flush on the 2nd beat of a refill.
  - Required: refill completes, then 32 FLUSH cycles, then 0x100 misses.
- Reset mid-refill:
  - Stimulus: assert reset after 2 beats.
  - Required: mem_read=0 and busy=0 immediately; a following fetch of the same pc misses.
